// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen: maps the beam position to an 8x8 sprite ROM address, scaled by 2**SCALE_LOG2, with a registered hit flag and pixel.
// Optional build macro SPRITE_MIRROR_EN adds i_mirror, which flips the sprite horizontally.
module sprite_addr_gen #(
    parameter int SCALE_LOG2 = 2,
    parameter int COORD_W    = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] i_hpos,
    input  logic [COORD_W-1:0] i_vpos,
    input  logic               i_frame_start,
    input  logic [COORD_W-1:0] i_sprite_x,
    input  logic [COORD_W-1:0] i_sprite_y,
`ifdef SPRITE_MIRROR_EN
    input  logic               i_mirror,
`endif
    input  logic               i_sprite_color,
    output logic [5:0]         o_rom_counter,
    output logic               o_in_box,
    output logic               o_pixel
);

    typedef enum logic {WAIT_FRAME, RUN} state_t;

    // One bit wider than a coordinate so boxes past the screen edge clip instead of wrapping.
    localparam logic [COORD_W:0] BOX = (COORD_W+1)'(8 << SCALE_LOG2);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [COORD_W:0]   x_end, y_end;
    logic [COORD_W-1:0] dx, dy;
    logic [2:0]         col, row;
    logic               hit, mirror;
    logic [5:0]         rom_q, rom_d;
    logic               in_box_q, in_box_d, pixel_q, pixel_d;

`ifdef SPRITE_MIRROR_EN
    logic mirror_q, mirror_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mirror_q <= 1'b0;
        else     mirror_q <= mirror_d;
    end

    assign mirror_d = i_frame_start ? i_mirror : mirror_q;
    assign mirror   = mirror_q;
`else
    assign mirror = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= WAIT_FRAME;
            pos_x_q  <= '0;
            pos_y_q  <= '0;
            rom_q    <= '0;
            in_box_q <= 1'b0;
            pixel_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            rom_q    <= rom_d;
            in_box_q <= in_box_d;
            pixel_q  <= pixel_d;
        end
    end

    // The position used this cycle is the one latched before any frame_start now present.
    always_comb begin
        state_d  = (state_q == WAIT_FRAME && i_frame_start) ? RUN : state_q;
        pos_x_d  = i_frame_start ? i_sprite_x : pos_x_q;
        pos_y_d  = i_frame_start ? i_sprite_y : pos_y_q;
        x_end    = {1'b0, pos_x_q} + BOX;
        y_end    = {1'b0, pos_y_q} + BOX;
        dx       = i_hpos - pos_x_q;
        dy       = i_vpos - pos_y_q;
        col      = 3'(dx >> SCALE_LOG2);
        row      = 3'(dy >> SCALE_LOG2);
        hit      = (state_q == RUN) && (i_hpos >= pos_x_q) && ({1'b0, i_hpos} < x_end)
                   && (i_vpos >= pos_y_q) && ({1'b0, i_vpos} < y_end);
        in_box_d = hit;
        rom_d    = hit ? {row, mirror ? ~col : col} : 6'd0;
        pixel_d  = (state_q == RUN) && in_box_q && i_sprite_color;
    end

    assign o_rom_counter = rom_q;
    assign o_in_box      = in_box_q;
    assign o_pixel       = pixel_q;

endmodule
